// File: rtl/deserializer.sv
// deserializer: rebuilds MSB-first serial packets into MSB-aligned parallel words with a bit count.
// Optional DESER_DROP_CNT_EN adds drop_cnt_o, a saturating count of discarded short packets.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
    parameter int MIN_PKT_LEN    = 3
) (
    input  logic                      clk_i,
    input  logic                      srst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_mod_o,
    output logic                      deser_val_o,
    output logic                      busy_o
`ifdef DESER_DROP_CNT_EN
   ,output logic [15:0]               drop_cnt_o
`endif
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [0:0]    IDLE_S   = 1'b0;
    localparam logic [0:0]    RECV_S   = 1'b1;
    localparam logic [W-1:0]  MSB      = W'(1) << (W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_PKT_LEN);
    logic [0:0]    state;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0]  sr, sr_nx;
    logic          full, ends, keep, drop;
    // cnt is always 0 in IDLE_S, so the write position MSB>>cnt serves both states
    always_comb begin
        sr_nx  = ((state == IDLE_S) ? '0 : sr) | (ser_data_i ? (MSB >> cnt) : '0);
        cnt_nx = cnt + 1'b1;
        full   = ser_data_val_i && cnt_nx == CNT_FULL;
        ends   = state == RECV_S && !ser_data_val_i;
        keep   = ends && cnt >= CNT_MIN;
        drop   = ends && cnt < CNT_MIN;
    end
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state        <= IDLE_S;
            cnt          <= '0;
            sr           <= '0;
            deser_data_o <= '0;
            deser_mod_o  <= '0;
            deser_val_o  <= 1'b0;
        end else begin
            state       <= (ser_data_val_i && !full) ? RECV_S : IDLE_S;
            cnt         <= (ser_data_val_i && !full) ? cnt_nx : '0;
            deser_val_o <= full || keep;
            if (ser_data_val_i)
                sr <= sr_nx;
            if (full) begin
                deser_data_o <= sr_nx;
                deser_mod_o  <= '0;
            end else if (keep) begin
                deser_data_o <= sr;
                deser_mod_o  <= cnt[DATA_MOD_WIDTH-1:0];
            end
        end
    end
`ifdef DESER_DROP_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!srst_n_i)
            drop_cnt_o <= '0;
        else if (drop && drop_cnt_o != 16'hFFFF)
            drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
    assign busy_o = state == RECV_S;
endmodule
